eth_fcs_tx_ctrl: RTL
====================

Name: eth_fcs_tx_ctrl

Overview:
TX-side sequencer for the combinational-update CRC-32 engine.
- Passes MAC frame bytes from the upstream byte stream to the downstream PHY-facing stream.
- Drives the engine's start, update and data inputs for every byte sent.
- Zero-pads short frames to the minimum length.
- Appends the 4-byte FCS taken from the engine result, least-significant byte first.
- Sits between the TX frame buffer and the TX PHY interface.

Parameters:
DATA_W, 8, byte width of both streams and of the CRC data input
CRC_W, 32, CRC result width (FCS is CRC_W/8 bytes)
MIN_LEN, 60, minimum frame length in bytes before the FCS; shorter frames are zero-padded; 0 disables padding
CNT_W, 11, width of the frame byte counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_data  in  DATA_W  upstream frame byte
s_valid  in  1  upstream byte valid
s_last  in  1  marks the final payload byte of the frame
s_ready  out  1  upstream ready
m_data  out  DATA_W  downstream byte (payload, pad or FCS)
m_valid  out  1  downstream valid
m_last  out  1  marks the final FCS byte
m_ready  in  1  downstream ready
crc_strt  out  1  one-cycle pulse: engine reinitialises its accumulator to all ones and processes this cycle's byte
crc_update  out  1  engine consumes crc_data this cycle
crc_data  out  DATA_W  byte fed to the engine
crc_result  in  CRC_W  final reflected and complemented CRC; valid the cycle after the last crc_update
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse on the handshake of the last FCS byte

Behaviour:
- Handshake: a transfer occurs when valid && ready on the same edge.
- m_data, m_valid and m_last are held stable while m_valid && !m_ready.
- Reset: state=IDLE, byte_cnt=0, fcs_idx=0, fcs_reg=0.
  - All outputs 0, except s_ready, which follows m_ready in IDLE.
  - Reset mid-frame abandons the frame; no FCS is emitted.
  - The next frame's crc_strt re-seeds the engine.
- States: IDLE, DATA, PAD, WAIT_CRC, FCS.
- IDLE and DATA (pass-through):
  - s_ready=m_ready, m_valid=s_valid, m_data=s_data, m_last=0.
  - crc_data=s_data, crc_update=s_valid&&m_ready.
  - crc_strt=crc_update in IDLE only.
  - Upstream handshake in IDLE: byte_cnt=1, go to DATA.
  - Upstream handshake in DATA: byte_cnt+1, saturating at 2^CNT_W-1.
- s_last on an upstream handshake (either state):
  - If the new byte_cnt < MIN_LEN, go to PAD.
  - Otherwise go to WAIT_CRC.
  - A single-byte frame (s_last on the first byte) is legal.
- PAD:
  - s_ready=0, m_valid=1, m_data=0, crc_data=0, crc_update=m_ready.
  - Each handshake increments byte_cnt.
  - On the handshake that makes byte_cnt==MIN_LEN, go to WAIT_CRC.
- WAIT_CRC: exactly one cycle.
  - s_ready=0, m_valid=0, crc_update=0.
  - fcs_reg<=crc_result, fcs_idx<=0, go to FCS.
- FCS:
  - s_ready=0, m_valid=1, m_data=fcs_reg[8*fcs_idx +: 8].
  - m_last=(fcs_idx==CRC_W/8-1), crc_update=0.
  - Each handshake increments fcs_idx.
  - Handshake with m_last: frame_done=1 for that cycle, byte_cnt=0, go to IDLE.
- Latency and throughput:
  - Payload: zero-cycle pass-through.
  - Exactly 1 idle output cycle (WAIT_CRC) between the last payload/pad byte and FCS byte 0.
  - Earliest next frame: the first cycle after return to IDLE. Upstream data presented during PAD/WAIT_CRC/FCS is stalled (s_ready=0), never dropped.
- Counts: crc_update asserts exactly max(payload_len, MIN_LEN) times per frame; crc_strt exactly once per frame.
- Frames longer than 2^CNT_W-1 bytes: counter saturates and passes through unchanged; length policing is upstream's job.

Test Plan:
- MIN_LEN=0; bytes "123456789" (0x31..0x39) with s_last on 0x39; engine model returns 0xCBF43926 -> 13 beats: 9 payload then 0x26,0x39,0xF4,0xCB; m_last and frame_done on 0xCB; 1 gap cycle before 0x26.
- MIN_LEN=60; 10-byte frame -> 50 zero pad beats; crc_update count 60; crc_strt once on byte 0; 64 total beats; m_last on beat 64.
- 100-byte frame with m_ready random 50% -> no PAD state; output equals input + FCS byte-exact; m_data stable during stalls; crc_update count 100.
- Back-to-back: frame B s_valid held high from FCS byte 0 of frame A -> s_ready=0 until IDLE; B byte 0 has crc_strt=1; no byte lost or duplicated.
- Single-byte frame 0xAA, MIN_LEN=60 -> 1 payload + 59 pad + 4 FCS; busy high from cycle after byte 0 until frame_done.
- rst asserted during FCS byte 2 -> next cycle m_valid=0, busy=0, state IDLE; following 64-byte frame emits correct FCS and exactly 68 beats.

Source files
------------

// File: rtl/eth_fcs_tx_ctrl_if.sv
// Byte-stream and CRC-engine bundle for the TX FCS sequencer.
// master = the sequencer, slave = the surrounding buffer/PHY/engine side.
interface eth_fcs_tx_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 32
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;
  logic              crc_strt;
  logic              crc_update;
  logic [DATA_W-1:0] crc_data;
  logic [CRC_W-1:0]  crc_result;

  modport master (
    input  s_data, s_valid, s_last, m_ready, crc_result,
    output s_ready, m_data, m_valid, m_last, crc_strt, crc_update, crc_data
  );

  modport slave (
    output s_data, s_valid, s_last, m_ready, crc_result,
    input  s_ready, m_data, m_valid, m_last, crc_strt, crc_update, crc_data
  );
endinterface

// File: rtl/eth_fcs_tx_ctrl.sv
// TX frame sequencer: passes payload through, zero-pads short frames and
// appends the CRC engine's FCS least-significant byte first.
module eth_fcs_tx_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CRC_W   = 32,
  parameter int MIN_LEN = 60,
  parameter int CNT_W   = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  eth_fcs_tx_ctrl_if.master      bus,
  output logic                   busy,
  output logic                   frame_done
);
  localparam int FCS_BYTES = CRC_W / DATA_W;
  localparam int IDX_W     = (FCS_BYTES > 1) ? $clog2(FCS_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FCS_BYTES - 1);
  localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD,
    ST_WAIT_CRC,
    ST_FCS
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]  fcs_idx_q, fcs_idx_d;
  logic [CRC_W-1:0]  fcs_reg_q, fcs_reg_d;

  logic              up_hs;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  cnt_next;

  // Counter saturates so oversize frames never wrap back into padding.
  assign cnt_inc = (byte_cnt_q == {CNT_W{1'b1}}) ? byte_cnt_q : byte_cnt_q + 1'b1;
  assign busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    fcs_idx_d      = fcs_idx_q;
    fcs_reg_d      = fcs_reg_q;
    up_hs          = 1'b0;
    cnt_next       = byte_cnt_q;
    bus.s_ready    = 1'b0;
    bus.m_valid    = 1'b0;
    bus.m_data     = '0;
    bus.m_last     = 1'b0;
    bus.crc_strt   = 1'b0;
    bus.crc_update = 1'b0;
    bus.crc_data   = '0;
    frame_done     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        up_hs          = bus.s_valid && bus.m_ready;
        bus.s_ready    = bus.m_ready;
        bus.m_valid    = bus.s_valid;
        bus.m_data     = bus.s_data;
        bus.crc_data   = bus.s_data;
        bus.crc_update = up_hs;
        bus.crc_strt   = up_hs && (state_q == ST_IDLE);
        cnt_next       = (state_q == ST_IDLE) ? CNT_W'(1) : cnt_inc;
        if (up_hs) begin
          byte_cnt_d = cnt_next;
          if (bus.s_last) begin
            state_d = (cnt_next < MIN_LEN_C) ? ST_PAD : ST_WAIT_CRC;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_PAD: begin
        bus.m_valid    = 1'b1;
        bus.crc_update = bus.m_ready;
        if (bus.m_ready) begin
          byte_cnt_d = cnt_inc;
          if (cnt_inc == MIN_LEN_C) begin
            state_d = ST_WAIT_CRC;
          end
        end
      end
      ST_WAIT_CRC: begin
        // Engine result reflects the final update from the previous cycle.
        fcs_reg_d = bus.crc_result;
        fcs_idx_d = '0;
        state_d   = ST_FCS;
      end
      ST_FCS: begin
        bus.m_valid = 1'b1;
        bus.m_data  = fcs_reg_q[DATA_W*int'(fcs_idx_q) +: DATA_W];
        bus.m_last  = (fcs_idx_q == LAST_IDX);
        if (bus.m_ready) begin
          fcs_idx_d = fcs_idx_q + 1'b1;
          if (fcs_idx_q == LAST_IDX) begin
            frame_done = 1'b1;
            byte_cnt_d = '0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      fcs_idx_q  <= '0;
      fcs_reg_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      fcs_idx_q  <= fcs_idx_d;
      fcs_reg_q  <= fcs_reg_d;
    end
  end
endmodule
